io_port_bank: RTL
=================

Name: io_port_bank

Overview:
- Parametrised memory-mapped I/O port bank; successor to the computer's fixed 16-in/16-out 8-bit port scheme.
- Sits between the CPU data bus and external pins. Provides:
  - PORT_COUNT input ports and PORT_COUNT output ports, each DATA_WIDTH wide.
  - 2-flop input synchronisers.
  - Per-port sticky change-detect flags with interrupt enables.
  - A registered read path.

Parameters:
- DATA_WIDTH, 8, width of each port and of the bus data; must be >= 2.
- PORT_COUNT, 16, number of input ports and number of output ports; 1..32.
- ADDR_WIDTH, 8, bus address width; 3*PORT_COUNT <= 2^ADDR_WIDTH.
- BASE_ADDR, 8'hC0, first address of the 3*PORT_COUNT-entry window.
- OUT_RESET, 0, reset value loaded into every output port register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_WIDTH  bus address.
- wr_en  in  1  write strobe, one cycle per write.
- rd_en  in  1  read strobe, one cycle per read.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  high one cycle after an accepted read.
- port_in  in  PORT_COUNT*DATA_WIDTH  flattened input pins; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- port_out  out  PORT_COUNT*DATA_WIDTH  flattened output registers, same packing.
- irq  out  1  level interrupt: OR over i of (flag[i] AND ien[i]).

Behaviour:
- Reset (asynchronous, active-high) sets:
  - all sync and history flops to 0;
  - port_out registers to OUT_RESET;
  - flag and ien to 0;
  - rd_data to 0, rd_valid to 0, irq to 0.
- Reset asserted mid-transaction aborts the transaction. No write takes effect in the cycle reset is high.
- Address decode: off = addr - BASE_ADDR. An access is in-window iff addr >= BASE_ADDR and off < 3*PORT_COUNT.
  - off 0..N-1: IN[i], read-only, returns sync2[i]. Writes are ignored.
  - off N..2N-1: OUT[i], read/write. Write loads port_out[i] at the clock edge. Read returns the current register value.
  - off 2N..3N-1: STAT[i], read/write.
    - Read returns {0..., ien[i], flag[i]} (bit1 = ien, bit0 = flag).
    - Write: bit0=1 clears flag[i]; bit1 loads ien[i]; upper bits are ignored.
- Out-of-window accesses:
  - Writes have no effect.
  - Reads return 0 and still pulse rd_valid.
- Read latency:
  - rd_en at edge k produces rd_data/rd_valid valid after edge k+1. rd_valid is high exactly one cycle.
  - rd_data holds its last value when no read is pending.
  - Back-to-back reads are allowed every cycle.
- Simultaneous wr_en and rd_en: both are performed. The read returns the pre-write value (read-before-write).
- Input path per port, advancing each cycle: sync1 <= port_in[i]; sync2 <= sync1; hist <= sync2.
- Change detect: when sync2 != hist, flag[i] sets (sticky). Latency from a pin change to the flag set is 3 edges.
- Flag set and W1C clear on the same port in the same cycle: set wins; flag stays 1.
- irq is combinational from the flag and ien registers. It goes high in the same cycle a flag with ien=1 is set, or when ien is written 1 on an already-set flag.
- Width rules: no arithmetic on data. Partial address compare uses ADDR_WIDTH bits and has no wrap-around. A window that would exceed 2^ADDR_WIDTH is a parameter error (elaboration assertion).

Test Plan:
- Reset: hold reset=1 with OUT_RESET=8'h5A.
  - Required: every port_out = 8'h5A, rd_data = 0, rd_valid = 0, irq = 0.
  - Release reset; read OUT[3] (addr C0+16+3 = D3). Required: rd_data = 5A, rd_valid = 1 one cycle later.
- Output write/readback: write 8'hA7 to addr D0.
  - Required: port_out[0] = A7 after the edge.
  - Same-cycle write 8'h11 plus read of D0 returns A7; a following read returns 11.
- Input sync and flag: set port_in[5] from 0 to 8'h3C.
  - Required: IN[5] read returns 3C from edge 2 onward; STAT[5] (addr E5) reads 01 after edge 3; irq stays 0 because ien=0.
- Interrupt: write 8'h02 to E5.
  - Required: irq = 1 immediately.
  - Write 8'h03 to E5. Required: flag clears, irq = 0, STAT[5] reads 02.
- Set-wins collision: arrange for port 2's flag set and a W1C write to E2 in the same cycle.
  - Required: STAT[2] bit0 = 1 afterwards.
- Out-of-window and mid-op reset: read addr 8'hF5. Required: rd_data = 0, rd_valid = 1.
  - Write D1 = FF with reset asserted in that cycle. Required: port_out[1] = OUT_RESET.

Source files
------------

// File: rtl/io_port_bank_if.sv
// CPU-side register bus of the I/O port bank: one address, separate write and
// read strobes, and a registered read return with a one-cycle valid pulse.
interface io_port_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output addr, wr_en, rd_en, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  addr, wr_en, rd_en, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped bank of PORT_COUNT input and output ports with 2-flop input
// synchronisers, sticky change-detect flags, interrupt enables and a registered read path.
module io_port_bank #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PORT_COUNT = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'hC0,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    io_port_bank_if.slave                    bus,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] port_in,
    output logic [PORT_COUNT*DATA_WIDTH-1:0] port_out,
    output logic                             irq
);

    // Window sizes carry one extra bit so a window ending exactly at 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] N1 = (ADDR_WIDTH+1)'(PORT_COUNT);
    localparam logic [ADDR_WIDTH:0] N2 = (ADDR_WIDTH+1)'(2 * PORT_COUNT);
    localparam logic [ADDR_WIDTH:0] N3 = (ADDR_WIDTH+1)'(3 * PORT_COUNT);

    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $error("io_port_bank: DATA_WIDTH must be at least 2");
    end
    if (PORT_COUNT < 1 || PORT_COUNT > 32) begin : g_bad_port_count
        $error("io_port_bank: PORT_COUNT must be in 1..32");
    end
    if ((64'(BASE_ADDR) + 64'(3 * PORT_COUNT)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_window
        $error("io_port_bank: register window exceeds the address space");
    end

    logic [DATA_WIDTH-1:0] pin      [PORT_COUNT];
    logic [DATA_WIDTH-1:0] sync1_q  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] sync1_d  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] sync2_q  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] sync2_d  [PORT_COUNT];
    logic [DATA_WIDTH-1:0] hist_q   [PORT_COUNT];
    logic [DATA_WIDTH-1:0] hist_d   [PORT_COUNT];
    logic [DATA_WIDTH-1:0] out_q    [PORT_COUNT];
    logic [DATA_WIDTH-1:0] out_d    [PORT_COUNT];
    logic [PORT_COUNT-1:0] flag_q;
    logic [PORT_COUNT-1:0] flag_d;
    logic [PORT_COUNT-1:0] ien_q;
    logic [PORT_COUNT-1:0] ien_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;

    logic [ADDR_WIDTH:0]   off;
    logic [ADDR_WIDTH:0]   idx_full;
    logic                  in_win;
    logic                  is_in;
    logic                  is_out;
    logic                  is_stat;
    logic [PORT_COUNT-1:0] sel_in;
    logic [PORT_COUNT-1:0] sel_out;
    logic [PORT_COUNT-1:0] sel_stat;
    logic [PORT_COUNT-1:0] chg;
    logic [PORT_COUNT-1:0] w1c;
    logic [DATA_WIDTH-1:0] rd_mux;

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_pack
        assign pin[i]                               = port_in[i*DATA_WIDTH +: DATA_WIDTH];
        assign port_out[i*DATA_WIDTH +: DATA_WIDTH] = out_q[i];
    end

    // Address decode; the lower-bound test keeps the subtraction from wrapping.
    always_comb begin
        off      = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
        in_win   = (bus.addr >= BASE_ADDR) && (off < N3);
        is_in    = in_win && (off < N1);
        is_out   = in_win && (off >= N1) && (off < N2);
        is_stat  = in_win && (off >= N2);
        idx_full = off;
        if (is_out) begin
            idx_full = off - N1;
        end else if (is_stat) begin
            idx_full = off - N2;
        end
        sel_in   = '0;
        sel_out  = '0;
        sel_stat = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (idx_full == (ADDR_WIDTH+1)'(i)) begin
                sel_in[i]   = is_in;
                sel_out[i]  = is_out;
                sel_stat[i] = is_stat;
            end
        end
    end

    // Read mux sees pre-edge register values, giving read-before-write on collisions.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (sel_in[i]) begin
                rd_mux = sync2_q[i];
            end
            if (sel_out[i]) begin
                rd_mux = out_q[i];
            end
            if (sel_stat[i]) begin
                rd_mux      = '0;
                rd_mux[1:0] = {ien_q[i], flag_q[i]};
            end
        end
        rd_data_d  = bus.rd_en ? rd_mux : rd_data_q;
        rd_valid_d = bus.rd_en;
    end

    always_comb begin
        for (int i = 0; i < PORT_COUNT; i++) begin
            sync1_d[i] = pin[i];
            sync2_d[i] = sync1_q[i];
            hist_d[i]  = sync2_q[i];
            out_d[i]   = (bus.wr_en && sel_out[i]) ? bus.wr_data : out_q[i];
            chg[i]     = (sync2_q[i] != hist_q[i]);
            w1c[i]     = bus.wr_en && sel_stat[i] && bus.wr_data[0];
            // A change arriving in the same cycle as a clear keeps the flag set.
            flag_d[i]  = chg[i] || (flag_q[i] && !w1c[i]);
            ien_d[i]   = (bus.wr_en && sel_stat[i]) ? bus.wr_data[1] : ien_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                sync1_q[i] <= '0;
                sync2_q[i] <= '0;
                hist_q[i]  <= '0;
                out_q[i]   <= OUT_RESET;
            end
            flag_q     <= '0;
            ien_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                sync1_q[i] <= sync1_d[i];
                sync2_q[i] <= sync2_d[i];
                hist_q[i]  <= hist_d[i];
                out_q[i]   <= out_d[i];
            end
            flag_q     <= flag_d;
            ien_q      <= ien_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign irq          = |(flag_q & ien_q);

endmodule
